// File: rtl/wb_data_cache.sv
// Direct-mapped, write-back, write-allocate data cache with one valid/ready request
// port and a block-wide handshaked memory port; misses and flushes run through one FSM.
module wb_data_cache #(
    parameter int WORD_SIZE   = 32,
    parameter int BLOCK_INDEX = 2,
    parameter int CACHE_INDEX = 4
) (
    input  logic                              clk,
    input  logic                              rst_n,
    // Request handshake: a request transfers on a rising clk edge where req_valid && req_ready.
    // req_ready is only high in IDLE with no flush pending; completion is the resp_valid pulse.
    input  logic                              req_valid,
    output logic                              req_ready,
    input  logic                              req_write,
    input  logic [WORD_SIZE-1:0]              req_addr,
    input  logic [WORD_SIZE-1:0]              req_wdata,
    output logic                              resp_valid,
    output logic [WORD_SIZE-1:0]              resp_rdata,
    output logic                              resp_hit,
    input  logic                              flush,
    output logic                              flush_done,
    output logic                              mem_req,
    output logic                              mem_we,
    output logic [WORD_SIZE-1:0]              mem_addr,
    output logic [WORD_SIZE*(2**BLOCK_INDEX)-1:0] mem_wblock,
    input  logic [WORD_SIZE*(2**BLOCK_INDEX)-1:0] mem_rblock,
    input  logic                              mem_ack
);

    localparam int BLOCK_SIZE = 2**BLOCK_INDEX;
    localparam int CACHE_SIZE = 2**CACHE_INDEX;
    localparam int TAG_SIZE   = WORD_SIZE - BLOCK_INDEX - CACHE_INDEX;
    localparam int LINE_W     = WORD_SIZE * BLOCK_SIZE;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        WRITEBACK,
        REFILL,
        FLUSH_SCAN,
        FLUSH_WB
    } state_t;

    state_t state_q, state_d;

    logic [LINE_W-1:0]      data_mem [CACHE_SIZE];
    logic [TAG_SIZE-1:0]    tag_mem  [CACHE_SIZE];
    logic [CACHE_SIZE-1:0]  valid_q;
    logic [CACHE_SIZE-1:0]  dirty_q;

    logic [WORD_SIZE-1:0]   addr_q;
    logic [WORD_SIZE-1:0]   wdata_q;
    logic                   write_q;
    logic                   first_q;
    logic [CACHE_INDEX-1:0] cnt_q;

    logic [TAG_SIZE-1:0]    req_tag;
    logic [CACHE_INDEX-1:0] req_idx;
    logic [BLOCK_INDEX-1:0] req_off;
    logic [LINE_W-1:0]      cur_line;
    logic [LINE_W-1:0]      merged_line;
    logic [WORD_SIZE-1:0]   cur_word;
    logic                   hit;
    logic                   victim_dirty;
    logic                   scan_dirty;
    logic                   last_line;

    logic                   accept;
    logic                   lookup_hit;
    logic                   lookup_miss;
    logic                   refill_done;
    logic                   flush_start;
    logic                   flush_wb_done;
    logic                   flush_end;
    logic                   cnt_inc;

    assign req_tag      = addr_q[WORD_SIZE-1 -: TAG_SIZE];
    assign req_idx      = addr_q[BLOCK_INDEX +: CACHE_INDEX];
    assign req_off      = addr_q[BLOCK_INDEX-1:0];
    assign cur_line     = data_mem[req_idx];
    assign hit          = valid_q[req_idx] && (tag_mem[req_idx] == req_tag);
    assign victim_dirty = valid_q[req_idx] && dirty_q[req_idx];
    assign scan_dirty   = valid_q[cnt_q] && dirty_q[cnt_q];
    assign last_line    = (cnt_q == {CACHE_INDEX{1'b1}});
    assign req_ready    = (state_q == IDLE) && !flush;

    // Offset 0 lives in the most significant word of a line.
    always_comb begin
        cur_word    = '0;
        merged_line = cur_line;
        for (int k = 0; k < BLOCK_SIZE; k++) begin
            if (req_off == BLOCK_INDEX'(k)) begin
                cur_word = cur_line[(BLOCK_SIZE-1-k)*WORD_SIZE +: WORD_SIZE];
                merged_line[(BLOCK_SIZE-1-k)*WORD_SIZE +: WORD_SIZE] = wdata_q;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        accept        = 1'b0;
        lookup_hit    = 1'b0;
        lookup_miss   = 1'b0;
        refill_done   = 1'b0;
        flush_start   = 1'b0;
        flush_wb_done = 1'b0;
        flush_end     = 1'b0;
        cnt_inc       = 1'b0;
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        mem_addr      = '0;
        mem_wblock    = '0;
        case (state_q)
            IDLE: begin
                if (flush) begin
                    flush_start = 1'b1;
                    state_d     = FLUSH_SCAN;
                end else if (req_valid) begin
                    accept  = 1'b1;
                    state_d = LOOKUP;
                end
            end
            LOOKUP: begin
                if (hit) begin
                    lookup_hit = 1'b1;
                    state_d    = IDLE;
                end else begin
                    lookup_miss = 1'b1;
                    state_d     = victim_dirty ? WRITEBACK : REFILL;
                end
            end
            WRITEBACK: begin
                mem_req    = 1'b1;
                mem_we     = 1'b1;
                mem_addr   = {tag_mem[req_idx], req_idx, {BLOCK_INDEX{1'b0}}};
                mem_wblock = cur_line;
                if (mem_ack) state_d = REFILL;
            end
            REFILL: begin
                mem_req  = 1'b1;
                mem_addr = {req_tag, req_idx, {BLOCK_INDEX{1'b0}}};
                if (mem_ack) begin
                    refill_done = 1'b1;
                    state_d     = LOOKUP;
                end
            end
            FLUSH_SCAN: begin
                if (scan_dirty) begin
                    state_d = FLUSH_WB;
                end else if (last_line) begin
                    flush_end = 1'b1;
                    state_d   = IDLE;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            FLUSH_WB: begin
                mem_req    = 1'b1;
                mem_we     = 1'b1;
                mem_addr   = {tag_mem[cnt_q], cnt_q, {BLOCK_INDEX{1'b0}}};
                mem_wblock = data_mem[cnt_q];
                if (mem_ack) begin
                    flush_wb_done = 1'b1;
                    if (last_line) begin
                        flush_end = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        cnt_inc = 1'b1;
                        state_d = FLUSH_SCAN;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            valid_q    <= '0;
            dirty_q    <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            write_q    <= 1'b0;
            first_q    <= 1'b0;
            cnt_q      <= '0;
            resp_valid <= 1'b0;
            resp_hit   <= 1'b0;
            resp_rdata <= '0;
            flush_done <= 1'b0;
        end else begin
            state_q    <= state_d;
            resp_valid <= lookup_hit;
            flush_done <= flush_end;
            if (accept) begin
                addr_q  <= req_addr;
                write_q <= req_write;
                wdata_q <= req_wdata;
                first_q <= 1'b1;
            end
            if (lookup_miss) first_q <= 1'b0;
            if (lookup_hit) begin
                resp_hit   <= first_q;
                resp_rdata <= write_q ? wdata_q : cur_word;
                if (write_q) dirty_q[req_idx] <= 1'b1;
            end
            if (refill_done) begin
                valid_q[req_idx] <= 1'b1;
                dirty_q[req_idx] <= 1'b0;
            end
            if (flush_wb_done) dirty_q[cnt_q] <= 1'b0;
            if (flush_start) begin
                cnt_q <= '0;
            end else if (cnt_inc) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    // Line data and tags carry no reset; valid bits guard them.
    always_ff @(posedge clk) begin
        if (refill_done) begin
            data_mem[req_idx] <= mem_rblock;
            tag_mem[req_idx]  <= req_tag;
        end else if (lookup_hit && write_q) begin
            data_mem[req_idx] <= merged_line;
        end
    end

endmodule

// File: tb/tb_wb_data_cache.sv
// Directed bench for wb_data_cache: a vector table of requests plus hand-written
// sequences for flush, flush/request priority, reset mid-writeback and memory latency.
module tb_wb_data_cache;

    localparam int W  = 32;
    localparam int BW = 128;
    localparam int NV = 12;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid, req_ready, req_write;
    logic [W-1:0]  req_addr, req_wdata;
    logic          resp_valid, resp_hit;
    logic [W-1:0]  resp_rdata;
    logic          flush, flush_done;
    logic          mem_req, mem_we, mem_ack;
    logic [W-1:0]  mem_addr;
    logic [BW-1:0] mem_wblock, mem_rblock;

    always #5 clk = ~clk;

    wb_data_cache #(.WORD_SIZE(32), .BLOCK_INDEX(2), .CACHE_INDEX(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_hit(resp_hit),
        .flush(flush), .flush_done(flush_done),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wblock(mem_wblock), .mem_rblock(mem_rblock), .mem_ack(mem_ack)
    );

    int total = 0;
    int bad   = 0;
    logic [W-1:0] exp_q[$];

    logic [BW-1:0] mem_model [logic [31:0]];
    logic          tr_we_q[$];
    logic [31:0]   tr_addr_q[$];
    logic [BW-1:0] tr_blk_q[$];
    int ack_delay      = 0;
    bit ack_hold       = 1'b0;
    int lat_cnt        = 0;
    int mem_req_cycles = 0;

    typedef struct {
        logic          wr;
        logic [31:0]   addr;
        logic [31:0]   wdata;
        logic [31:0]   exp_rdata;
        logic          exp_hit;
        int            exp_edges;
        int            exp_ntrans;
        logic          exp_we0;
        logic [31:0]   exp_addr0;
        logic [BW-1:0] exp_blk0;
    } vec_t;

    vec_t vecs [NV];

    // Memory responder: acks after ack_delay extra cycles, logs every completed transaction.
    always @(negedge clk) begin
        if (mem_req) mem_req_cycles++;
        if (!rst_n || !mem_req || ack_hold) begin
            mem_ack = 1'b0;
            lat_cnt = 0;
        end else if (lat_cnt >= ack_delay) begin
            mem_ack = 1'b1;
            lat_cnt = 0;
            tr_we_q.push_back(mem_we);
            tr_addr_q.push_back(mem_addr);
            tr_blk_q.push_back(mem_wblock);
            if (mem_we) mem_model[mem_addr] = mem_wblock;
            else mem_rblock = mem_model.exists(mem_addr) ? mem_model[mem_addr] : '0;
        end else begin
            mem_ack = 1'b0;
            lat_cnt++;
        end
    end

    task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_log();
        tr_we_q.delete();
        tr_addr_q.delete();
        tr_blk_q.delete();
        mem_req_cycles = 0;
    endtask

    // edges counts posedges from the accepting edge (inclusive) to the one raising resp_valid.
    task automatic do_req(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                          output logic [31:0] rd, output logic h, output int edges);
        int n;
        @(negedge clk);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = a;
        req_wdata = wd;
        n = 0;
        while (!req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        edges = 1;
        @(negedge clk);
        req_valid = 1'b0;
        while (!resp_valid && edges < 200) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        check("req_timeout", resp_valid, 1'b1);
        rd = resp_rdata;
        h  = resp_hit;
    endtask

    task automatic do_flush(output int edges, output int pulses);
        bit done;
        @(negedge clk);
        flush  = 1'b1;
        edges  = 0;
        pulses = 0;
        done   = 1'b0;
        while (!done && edges < 400) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            if (flush_done) begin
                done = 1'b1;
                pulses++;
                flush = 1'b0;
            end
        end
        check("flush_timeout", done, 1'b1);
        flush = 1'b0;
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            if (flush_done) pulses++;
        end
    endtask

    initial begin
        logic [31:0]   rd;
        logic          h;
        int            ed, pulses, n, early_resp;
        bit            done;
        logic [BW-1:0] blk_a;

        rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
        flush = 1'b0; mem_ack = 1'b0; mem_rblock = '0;

        mem_model[32'h10] = {32'h11, 32'h22, 32'h33, 32'h44};
        mem_model[32'h50] = {32'hA0, 32'hA1, 32'hA2, 32'hA3};
        mem_model[32'h08] = {32'hB0, 32'hB1, 32'hB2, 32'hB3};
        mem_model[32'h24] = {32'hC0, 32'hC1, 32'hC2, 32'hC3};
        mem_model[32'h70] = {32'hD0, 32'hD1, 32'hD2, 32'hD3};
        mem_model[32'hB0] = {32'hD0, 32'hD1, 32'hD2, 32'hD3};

        //            wr    addr    wdata          rdata          hit  edg ntr we0   addr0   blk0
        vecs[0]  = '{1'b0, 32'h13, 32'h0,        32'h44,        1'b0, 4, 1, 1'b0, 32'h10, '0};
        vecs[1]  = '{1'b0, 32'h13, 32'h0,        32'h44,        1'b1, 2, 0, 1'b0, 32'h0,  '0};
        vecs[2]  = '{1'b0, 32'h10, 32'h0,        32'h11,        1'b1, 2, 0, 1'b0, 32'h0,  '0};
        vecs[3]  = '{1'b1, 32'h13, 32'hDEADBEEF, 32'hDEADBEEF,  1'b1, 2, 0, 1'b0, 32'h0,  '0};
        vecs[4]  = '{1'b0, 32'h13, 32'h0,        32'hDEADBEEF,  1'b1, 2, 0, 1'b0, 32'h0,  '0};
        vecs[5]  = '{1'b0, 32'h53, 32'h0,        32'hA3,        1'b0, 5, 2, 1'b1, 32'h10,
                     {32'h11, 32'h22, 32'h33, 32'hDEADBEEF}};
        vecs[6]  = '{1'b0, 32'h52, 32'h0,        32'hA2,        1'b1, 2, 0, 1'b0, 32'h0,  '0};
        vecs[7]  = '{1'b0, 32'h13, 32'h0,        32'hDEADBEEF,  1'b0, 4, 1, 1'b0, 32'h10, '0};
        vecs[8]  = '{1'b1, 32'h08, 32'h12345678, 32'h12345678,  1'b0, 4, 1, 1'b0, 32'h08, '0};
        vecs[9]  = '{1'b0, 32'h09, 32'h0,        32'hB1,        1'b1, 2, 0, 1'b0, 32'h0,  '0};
        vecs[10] = '{1'b1, 32'h24, 32'hCAFE0001, 32'hCAFE0001,  1'b0, 4, 1, 1'b0, 32'h24, '0};
        vecs[11] = '{1'b0, 32'h24, 32'h0,        32'hCAFE0001,  1'b1, 2, 0, 1'b0, 32'h0,  '0};

        // Reset values, during and just after reset.
        repeat (3) @(negedge clk);
        check("rst_req_ready",  req_ready,  1'b1);
        check("rst_resp_valid", resp_valid, 1'b0);
        check("rst_resp_hit",   resp_hit,   1'b0);
        check("rst_resp_rdata", resp_rdata, 32'h0);
        check("rst_flush_done", flush_done, 1'b0);
        check("rst_mem_req",    mem_req,    1'b0);
        check("rst_mem_we",     mem_we,     1'b0);
        check("rst_mem_addr",   mem_addr,   32'h0);
        check("rst_mem_wblock", mem_wblock, '0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_mem_req", mem_req, 1'b0);

        // Vector table.
        for (int i = 0; i < NV; i++) begin
            clear_log();
            do_req(vecs[i].wr, vecs[i].addr, vecs[i].wdata, rd, h, ed);
            check($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rdata);
            check($sformatf("v%0d_hit", i), h, vecs[i].exp_hit);
            check($sformatf("v%0d_edges", i), ed, vecs[i].exp_edges);
            check($sformatf("v%0d_ntrans", i), tr_addr_q.size(), vecs[i].exp_ntrans);
            if (vecs[i].exp_ntrans > 0 && tr_addr_q.size() > 0) begin
                check($sformatf("v%0d_we0", i), tr_we_q[0], vecs[i].exp_we0);
                check($sformatf("v%0d_addr0", i), tr_addr_q[0], vecs[i].exp_addr0);
                if (vecs[i].exp_we0) check($sformatf("v%0d_blk0", i), tr_blk_q[0], vecs[i].exp_blk0);
            end
            if (vecs[i].exp_ntrans == 2 && tr_addr_q.size() == 2) begin
                check($sformatf("v%0d_we1", i), tr_we_q[1], 1'b0);
                check($sformatf("v%0d_addr1", i), tr_addr_q[1], 32'h50);
            end
            @(posedge clk);
            @(negedge clk);
            check($sformatf("v%0d_resp_pulse", i), resp_valid, 1'b0);
        end

        // Flush with lines 2 and 9 dirty.
        clear_log();
        exp_q = {32'h08, 32'h24};
        do_flush(ed, pulses);
        check("flush1_edges", ed, 19);
        check("flush1_pulses", pulses, 1);
        check("flush1_ntrans", tr_addr_q.size(), 2);
        if (tr_addr_q.size() == 2) begin
            check("flush1_we0",   tr_we_q[0],   1'b1);
            check("flush1_addr0", tr_addr_q[0], exp_q[0]);
            check("flush1_blk0",  tr_blk_q[0],  {32'h12345678, 32'hB1, 32'hB2, 32'hB3});
            check("flush1_we1",   tr_we_q[1],   1'b1);
            check("flush1_addr1", tr_addr_q[1], exp_q[1]);
            check("flush1_blk1",  tr_blk_q[1],  {32'hCAFE0001, 32'hC1, 32'hC2, 32'hC3});
        end

        // Second flush finds nothing dirty.
        clear_log();
        do_flush(ed, pulses);
        check("flush2_edges", ed, 17);
        check("flush2_pulses", pulses, 1);
        check("flush2_mem_req_cycles", mem_req_cycles, 0);

        // Flush and request together: flush first, then the request.
        clear_log();
        @(negedge clk);
        flush = 1'b1; req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h13;
        #1;
        check("prio_req_ready", req_ready, 1'b0);
        ed = 0; early_resp = 0; done = 1'b0;
        while (!done && ed < 100) begin
            @(posedge clk);
            ed++;
            @(negedge clk);
            if (resp_valid) early_resp++;
            if (flush_done) begin
                done = 1'b1;
                flush = 1'b0;
            end
        end
        flush = 1'b0;
        check("prio_flush_edges", ed, 17);
        check("prio_early_resp", early_resp, 0);
        @(posedge clk);
        ed = 1;
        @(negedge clk);
        req_valid = 1'b0;
        while (!resp_valid && ed < 50) begin
            @(posedge clk);
            ed++;
            @(negedge clk);
        end
        check("prio_resp_edges", ed, 2);
        check("prio_rdata", resp_rdata, 32'hDEADBEEF);
        check("prio_hit", resp_hit, 1'b1);

        // Reset while a writeback is pending.
        do_req(1'b1, 32'h13, 32'h5555, rd, h, ed);
        check("rstwb_store_hit", h, 1'b1);
        ack_hold = 1'b1;
        clear_log();
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h53;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        n = 0;
        while (!(mem_req && mem_we) && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("rstwb_wb_seen", mem_req && mem_we, 1'b1);
        check("rstwb_wb_addr", mem_addr, 32'h10);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rstwb_mem_req_drop", mem_req, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        ack_hold = 1'b0;
        #1;
        check("rstwb_req_ready", req_ready, 1'b1);
        clear_log();
        do_req(1'b0, 32'h13, 32'h0, rd, h, ed);
        check("rstwb_reload_hit", h, 1'b0);
        check("rstwb_reload_rdata", rd, 32'hDEADBEEF);
        check("rstwb_reload_edges", ed, 4);
        check("rstwb_reload_ntrans", tr_addr_q.size(), 1);
        if (tr_addr_q.size() == 1) check("rstwb_reload_we", tr_we_q[0], 1'b0);

        // Store-miss at memory latency 0, then a conflicting store-miss at latency 5.
        clear_log();
        do_req(1'b1, 32'h71, 32'h77, rd, h, ed);
        check("lat0_rdata", rd, 32'h77);
        check("lat0_hit", h, 1'b0);
        check("lat0_edges", ed, 4);
        ack_delay = 5;
        clear_log();
        do_req(1'b1, 32'hB1, 32'h77, rd, h, ed);
        check("lat5_rdata", rd, 32'h77);
        check("lat5_hit", h, 1'b0);
        check("lat5_edges", ed, 15);
        check("lat5_ntrans", tr_addr_q.size(), 2);
        blk_a = '0;
        if (tr_addr_q.size() == 2) begin
            blk_a = tr_blk_q[0];
            check("lat5_wb_we", tr_we_q[0], 1'b1);
            check("lat5_wb_addr", tr_addr_q[0], 32'h70);
            check("lat5_wb_blk", blk_a, {32'hD0, 32'h77, 32'hD2, 32'hD3});
            check("lat5_rf_addr", tr_addr_q[1], 32'hB0);
        end
        clear_log();
        do_flush(ed, pulses);
        check("lat5_flush_edges", ed, 23);
        check("lat5_flush_ntrans", tr_addr_q.size(), 1);
        if (tr_addr_q.size() == 1) begin
            check("lat5_flush_addr", tr_addr_q[0], 32'hB0);
            check("lat5_flush_blk", tr_blk_q[0], {32'hD0, 32'h77, 32'hD2, 32'hD3});
        end
        ack_delay = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
